// File: rtl/apb_bridge_arbiter.sv
// Arbiter sharing one APB bridge among NUM_REQ AHB requesters.
// Round-robin, fixed-priority or weighted round-robin, with BUSY timeout.
module apb_bridge_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ARB_TYPE = 0,
  parameter int TIMEOUT  = 256,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 done,
  input  logic [4*NUM_REQ-1:0] weight_cfg,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IW-1:0]        grant_idx,
  output logic                 busy,
  output logic                 timeout
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [CW-1:0] CMAX =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [3:0]    credit [NUM_REQ];

  logic [IW-1:0] rr_idx;
  logic [IW-1:0] fp_idx;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] jj;
  logic          found;
  logic          hold;
  logic          reload;
  logic [3:0]    wsel;
  logic [3:0]    rld;
  logic          expire;
  logic          release_now;

  // rr_idx searches from ptr+1 and wraps back to ptr itself last
  always_comb begin
    rr_idx = '0;
    fp_idx = '0;
    found  = 1'b0;
    jj     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      jj = IW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[jj]) begin
        found  = 1'b1;
        rr_idx = jj;
      end
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) fp_idx = IW'(k);
    end
  end

  always_comb begin
    hold    = req[ptr] && (credit[ptr] != 4'd0);
    win_idx = rr_idx;
    reload  = 1'b0;
    unique case (1'b1)
      (ARB_TYPE == 1): win_idx = fp_idx;
      (ARB_TYPE == 2): begin
        if (hold) win_idx = ptr;
        else      reload  = 1'b1;
      end
      default: win_idx = rr_idx;
    endcase
    wsel = weight_cfg[4*int'(win_idx) +: 4];
    rld  = (wsel == 4'd0) ? 4'd1 : wsel;
  end

  // done wins over a coinciding timeout
  assign expire = (TIMEOUT != 0) && (state == BUSY) &&
                  (cnt == CMAX) && !done;
  assign release_now = (state == BUSY) && (done || expire);
  assign timeout = expire;
  assign busy    = (state == BUSY);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= IW'(NUM_REQ - 1);
      cnt       <= '0;
      for (int i = 0; i < NUM_REQ; i++) credit[i] <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            state     <= BUSY;
            grant     <= NUM_REQ'(1) << win_idx;
            grant_idx <= win_idx;
            ptr       <= win_idx;
            cnt       <= '0;
            if (reload) credit[win_idx] <= rld;
          end
        end
        BUSY: begin
          cnt <= cnt + CW'(1);
          if (release_now) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            if (ARB_TYPE == 2 && credit[grant_idx] != 4'd0)
              credit[grant_idx] <= credit[grant_idx] - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// Directed bench for apb_bridge_arbiter in RR, fixed and weighted modes.
// Three instances share one clock and reset.
module tb_apb_bridge_arbiter;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;

  always #5 HCLK = ~HCLK;

  logic [3:0]  req_a, req_b, req_c;
  logic        done_a, done_b, done_c;
  logic [15:0] wcfg_a, wcfg_b, wcfg_c;
  logic [3:0]  grant_a, grant_b, grant_c;
  logic [1:0]  idx_a, idx_b, idx_c;
  logic        busy_a, busy_b, busy_c;
  logic        to_a, to_b, to_c;

  int checks = 0;
  int failures = 0;

  apb_bridge_arbiter #(.NUM_REQ(4), .ARB_TYPE(0), .TIMEOUT(8)) u_rr (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req_a), .done(done_a),
    .weight_cfg(wcfg_a), .grant(grant_a), .grant_idx(idx_a),
    .busy(busy_a), .timeout(to_a)
  );

  apb_bridge_arbiter #(.NUM_REQ(4), .ARB_TYPE(1), .TIMEOUT(0)) u_fp (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req_b), .done(done_b),
    .weight_cfg(wcfg_b), .grant(grant_b), .grant_idx(idx_b),
    .busy(busy_b), .timeout(to_b)
  );

  apb_bridge_arbiter #(.NUM_REQ(4), .ARB_TYPE(2), .TIMEOUT(0)) u_wrr (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req_c), .done(done_c),
    .weight_cfg(wcfg_c), .grant(grant_c), .grant_idx(idx_c),
    .busy(busy_c), .timeout(to_c)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int rr_exp [5] = '{0, 1, 2, 3, 0};
  int wr_exp [8] = '{0, 1, 1, 1, 2, 3, 3, 0};

  initial begin
    req_a = '0; req_b = '0; req_c = '0;
    done_a = 0; done_b = 0; done_c = 0;
    wcfg_a = 16'h0; wcfg_b = 16'h0;
    wcfg_c = 16'h2031;
    step(); step();
    HRESETn = 1'b1;
    step();

    chk("rst_grant", 32'(grant_a), 32'h0);
    chk("rst_idx", 32'(idx_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_to", 32'(to_a), 32'h0);

    // idle with no request; done ignored
    done_a = 1;
    step();
    done_a = 0;
    step();
    chk("idle_busy", 32'(busy_a), 32'h0);
    chk("idle_grant", 32'(grant_a), 32'h0);

    // round-robin sequence
    req_a = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rr_busy%0d", i), 32'(busy_a), 32'h1);
      chk($sformatf("rr_idx%0d", i), 32'(idx_a), 32'(rr_exp[i]));
      chk($sformatf("rr_gnt%0d", i), 32'(grant_a),
          32'(1) << rr_exp[i]);
      done_a = 1;
      if (i == 4) req_a = 4'b0000;
      step();
      done_a = 0;
      chk($sformatf("rr_gap%0d", i), 32'(busy_a), 32'h0);
      chk($sformatf("rr_gapg%0d", i), 32'(grant_a), 32'h0);
    end

    // fixed priority, then req drop
    req_b = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fp_idx%0d", i), 32'(idx_b), 32'h1);
      if (i == 2) begin
        req_b = 4'b1000;
        step();
        chk("fp_hold_idx", 32'(idx_b), 32'h1);
        chk("fp_hold_busy", 32'(busy_b), 32'h1);
      end
      done_b = 1;
      step();
      done_b = 0;
      chk($sformatf("fp_gap%0d", i), 32'(busy_b), 32'h0);
    end
    step();
    chk("fp_idx3", 32'(idx_b), 32'h3);
    chk("fp_gnt3", 32'(grant_b), 32'h8);
    req_b = 4'b0000;
    done_b = 1;
    step();
    done_b = 0;

    // weighted round-robin
    req_c = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("wr_idx%0d", i), 32'(idx_c), 32'(wr_exp[i]));
      chk($sformatf("wr_busy%0d", i), 32'(busy_c), 32'h1);
      done_c = 1;
      if (i == 7) req_c = 4'b0000;
      step();
      done_c = 0;
      chk($sformatf("wr_gap%0d", i), 32'(busy_c), 32'h0);
    end

    // timeout with no done
    req_a = 4'b0001;
    step();
    req_a = 4'b0000;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("to_pulse%0d", c), 32'(to_a),
          (c == 8) ? 32'h1 : 32'h0);
      chk($sformatf("to_busy%0d", c), 32'(busy_a), 32'h1);
      if (c < 8) step();
    end
    step();
    chk("to_rel_busy", 32'(busy_a), 32'h0);
    chk("to_rel_gnt", 32'(grant_a), 32'h0);
    chk("to_rel_to", 32'(to_a), 32'h0);

    // done on the timeout cycle wins
    req_a = 4'b0001;
    step();
    req_a = 4'b0000;
    for (int c = 1; c < 8; c++) step();
    done_a = 1;
    #1;
    chk("td_to", 32'(to_a), 32'h0);
    chk("td_busy", 32'(busy_a), 32'h1);
    step();
    done_a = 0;
    chk("td_rel_busy", 32'(busy_a), 32'h0);
    chk("td_rel_to", 32'(to_a), 32'h0);

    // reset mid-BUSY
    req_a = 4'b1111;
    step();
    chk("mr_busy", 32'(busy_a), 32'h1);
    chk("mr_idx", 32'(idx_a), 32'h1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("mr_gnt0", 32'(grant_a), 32'h0);
    chk("mr_busy0", 32'(busy_a), 32'h0);
    chk("mr_to0", 32'(to_a), 32'h0);
    step();
    HRESETn = 1'b1;
    step();
    chk("mr_idx_after", 32'(idx_a), 32'h0);
    chk("mr_gnt_after", 32'(grant_a), 32'h1);
    req_a = 4'b0000;
    done_a = 1;
    step();
    done_a = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
